// File: rtl/pulpino_boot_pkg.sv
// Shared types and defaults for the PULPino boot/run sequencer.
package pulpino_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_ARM      = 3'd2,
    ST_RUN      = 3'd3,
    ST_HALT     = 3'd4
  } boot_state_e;

  localparam int BOOT_CNT_W = 8;
  localparam int CYC_CNT_W  = 32;

  localparam logic [31:0] DEF_BOOT_ADDR       = 32'h0000_8000;
  localparam int unsigned DEF_RST_HOLD_CYCLES = 16;
  localparam int unsigned DEF_FETCH_DELAY     = 8;
  localparam int unsigned DEF_WDT_TIMEOUT     = 1000000;

  function automatic logic [BOOT_CNT_W-1:0] sat_inc(input logic [BOOT_CNT_W-1:0] v);
    return (&v) ? v : v + BOOT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pulpino_boot_wdt.sv
// Heartbeat watchdog: any change on the heartbeat bus while running is a kick;
// expire is raised in the cycle the counter hits TIMEOUT-1 without a kick.
module pulpino_boot_wdt
  import pulpino_boot_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_WDT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] heartbeat,
  output logic        expire
);

  logic [CYC_CNT_W-1:0] cnt;
  logic [31:0]          prev;
  logic                 run_d;
  logic                 kick;

  // The first RUN cycle only captures the heartbeat; it can never count as a kick.
  assign kick   = run && run_d && (heartbeat != prev);
  assign expire = run && !kick && (cnt == CYC_CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      prev  <= '0;
      run_d <= 1'b0;
    end else begin
      prev  <= heartbeat;
      run_d <= run;
      if (!run || kick) cnt <= '0;
      else              cnt <= cnt + CYC_CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulpino_boot_ctrl.sv
// Boot/run sequencer for the PULPino core: reset hold, fetch arm, run, JTAG halt.
// Optional heartbeat watchdog enabled by defining PULPINO_BOOT_WDT_EN.
module pulpino_boot_ctrl
  import pulpino_boot_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR_DEFAULT = DEF_BOOT_ADDR,
  parameter int unsigned RST_HOLD_CYCLES   = DEF_RST_HOLD_CYCLES,
  parameter int unsigned FETCH_DELAY       = DEF_FETCH_DELAY,
  parameter int unsigned WDT_TIMEOUT       = DEF_WDT_TIMEOUT
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  dbg_reset_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  boot_addr_we_i,
  input  logic [31:0]           boot_addr_data_i,
  input  logic [31:0]           heartbeat_i,
  output logic                  core_rst_n_o,
  output logic                  fetch_enable_o,
  output logic [31:0]           boot_addr_o,
  output logic                  testmode_o,
  output logic                  clock_gating_o,
  output logic [2:0]            state_o,
  output logic                  wdt_expired_o,
  output logic [BOOT_CNT_W-1:0] boot_count_o
);

  boot_state_e          state, next_state;
  logic [CYC_CNT_W-1:0] cnt, cnt_next;
  logic                 wdt_expire;
  logic                 wdt_fire;
  logic                 in_run;

  assign in_run         = (state == ST_RUN);
  assign state_o        = state;
  assign testmode_o     = 1'b0;
  assign clock_gating_o = 1'b0;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    wdt_fire   = 1'b0;
    unique case (state)
      ST_IDLE: if (start_i) next_state = ST_RST_HOLD;
      ST_RST_HOLD: begin
        if (dbg_reset_i)                                   next_state = ST_HALT;
        else if (stop_i)                                   next_state = ST_IDLE;
        else if (cnt == CYC_CNT_W'(RST_HOLD_CYCLES - 1))   next_state = ST_ARM;
      end
      ST_ARM: begin
        if (dbg_reset_i)                                   next_state = ST_HALT;
        else if (stop_i)                                   next_state = ST_IDLE;
        else if (cnt == CYC_CNT_W'(FETCH_DELAY - 1))       next_state = ST_RUN;
      end
      ST_RUN: begin
        if (dbg_reset_i)      next_state = ST_HALT;
        else if (stop_i)      next_state = ST_IDLE;
        else if (wdt_expire) begin
          next_state = ST_RST_HOLD;
          wdt_fire   = 1'b1;
        end
      end
      ST_HALT: begin
        if (dbg_reset_i)      next_state = ST_HALT;
        else if (stop_i)      next_state = ST_IDLE;
        else                  next_state = ST_RST_HOLD;
      end
      default:                next_state = ST_IDLE;
    endcase

    // Phase counter restarts on every state change, so HALT always clears it.
    cnt_next = '0;
    if (next_state == state && (state == ST_RST_HOLD || state == ST_ARM))
      cnt_next = cnt + CYC_CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      core_rst_n_o   <= 1'b0;
      fetch_enable_o <= 1'b0;
      boot_addr_o    <= BOOT_ADDR_DEFAULT;
      boot_count_o   <= '0;
    end else begin
      state          <= next_state;
      cnt            <= cnt_next;
      core_rst_n_o   <= (next_state == ST_ARM) || (next_state == ST_RUN);
      fetch_enable_o <= (next_state == ST_RUN);
      if (boot_addr_we_i && (state == ST_IDLE || state == ST_HALT))
        boot_addr_o <= boot_addr_data_i;
      if (next_state == ST_RUN && state != ST_RUN)
        boot_count_o <= sat_inc(boot_count_o);
    end
  end

`ifdef PULPINO_BOOT_WDT_EN
  logic wdt_expired_q;

  pulpino_boot_wdt #(
    .TIMEOUT(WDT_TIMEOUT)
  ) u_wdt (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .run      (in_run),
    .heartbeat(heartbeat_i),
    .expire   (wdt_expire)
  );

  // Sticky until software restarts the core from IDLE.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)                  wdt_expired_q <= 1'b0;
    else if (wdt_fire)                   wdt_expired_q <= 1'b1;
    else if (state == ST_IDLE && start_i) wdt_expired_q <= 1'b0;
  end

  assign wdt_expired_o = wdt_expired_q;
`else
  logic unused_wdt;
  assign wdt_expire    = 1'b0;
  assign wdt_expired_o = 1'b0;
  assign unused_wdt    = ^{heartbeat_i, wdt_fire, in_run, 32'(WDT_TIMEOUT)};
`endif

endmodule

// File: tb/tb_pulpino_boot_ctrl.sv
// Directed self-checking bench for pulpino_boot_ctrl (RST_HOLD=4, FETCH_DELAY=2, WDT_TIMEOUT=16).
module tb_pulpino_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dbg_reset, start, stop, we;
  logic [31:0] data, heartbeat;
  logic        core_rst_n, fetch_en, testmode, clock_gating, wdt_expired;
  logic [31:0] boot_addr;
  logic [2:0]  state;
  logic [7:0]  boot_count;
  logic        fetch_seen;
  logic        left_run;

  int n_checks = 0;
  int n_errors = 0;

  pulpino_boot_ctrl #(
    .BOOT_ADDR_DEFAULT(32'h0000_8000),
    .RST_HOLD_CYCLES  (4),
    .FETCH_DELAY      (2),
    .WDT_TIMEOUT      (16)
  ) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .dbg_reset_i     (dbg_reset),
    .start_i         (start),
    .stop_i          (stop),
    .boot_addr_we_i  (we),
    .boot_addr_data_i(data),
    .heartbeat_i     (heartbeat),
    .core_rst_n_o    (core_rst_n),
    .fetch_enable_o  (fetch_en),
    .boot_addr_o     (boot_addr),
    .testmode_o      (testmode),
    .clock_gating_o  (clock_gating),
    .state_o         (state),
    .wdt_expired_o   (wdt_expired),
    .boot_count_o    (boot_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start pulse, then advance to the first RUN cycle (c7).
  task automatic boot_seq();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
  endtask

  initial begin
    rst_n = 1'b0; dbg_reset = 1'b0; start = 1'b0; stop = 1'b0;
    we = 1'b0; data = '0; heartbeat = 32'h0;
    step(2);
    check("rst_state", state, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_fetch", fetch_en, 0);
    check("rst_boot_addr", boot_addr, 32'h0000_8000);
    check("rst_testmode", testmode, 0);
    check("rst_clock_gating", clock_gating, 0);
    check("rst_wdt_expired", wdt_expired, 0);
    check("rst_boot_count", boot_count, 0);
    rst_n = 1'b1;
    step(1);
    check("idle_after_rst", state, 0);

    // Boot latency
    start = 1'b1; step(1); start = 1'b0;
    check("c1_state", state, 1);
    check("c1_core_rst_n", core_rst_n, 0);
    step(3);
    check("c4_core_rst_n", core_rst_n, 0);
    step(1);
    check("c5_core_rst_n", core_rst_n, 1);
    check("c5_state", state, 2);
    step(1);
    check("c6_fetch", fetch_en, 0);
    step(1);
    check("c7_fetch", fetch_en, 1);
    check("c7_state", state, 3);
    check("c7_boot_count", boot_count, 1);
    check("c7_boot_addr", boot_addr, 32'h0000_8000);

    // Boot address write ignored in RUN, accepted in IDLE
    we = 1'b1; data = 32'h1C00_0080; step(1); we = 1'b0;
    check("we_in_run_ignored", boot_addr, 32'h0000_8000);
    stop = 1'b1; step(1); stop = 1'b0;
    check("stop_run_state", state, 0);
    check("stop_run_core_rst_n", core_rst_n, 0);
    check("stop_run_fetch", fetch_en, 0);
    we = 1'b1; step(1); we = 1'b0;
    check("we_in_idle", boot_addr, 32'h1C00_0080);
    boot_seq();
    check("boot2_state", state, 3);
    check("boot2_addr", boot_addr, 32'h1C00_0080);
    check("boot2_count", boot_count, 2);

    // JTAG halt for 10 cycles, with a boot address write while halted
    dbg_reset = 1'b1; step(1);
    check("halt_state", state, 4);
    check("halt_core_rst_n", core_rst_n, 0);
    check("halt_fetch", fetch_en, 0);
    step(4);
    we = 1'b1; data = 32'h0000_0200; step(1); we = 1'b0;
    check("we_in_halt", boot_addr, 32'h0000_0200);
    step(4);
    check("halt_hold", state, 4);
    dbg_reset = 1'b0; step(1);
    check("halt_release_reboot", state, 1);
    step(6);
    check("reboot_state", state, 3);
    check("reboot_count", boot_count, 3);
    check("reboot_addr", boot_addr, 32'h0000_0200);

    // dbg_reset beats stop_i in RUN; stop_i in HALT returns to IDLE
    dbg_reset = 1'b1; stop = 1'b1; step(1); dbg_reset = 1'b0;
    check("dbg_over_stop", state, 4);
    step(1); stop = 1'b0;
    check("stop_in_halt", state, 0);

    // dbg_reset ignored in IDLE
    dbg_reset = 1'b1; step(2); dbg_reset = 1'b0;
    check("dbg_in_idle", state, 0);

    // stop_i in ARM: fetch never asserted
    fetch_seen = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      fetch_seen |= fetch_en;
    end
    check("arm_state", state, 2);
    stop = 1'b1; step(1); stop = 1'b0;
    check("stop_arm_state", state, 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      fetch_seen |= fetch_en;
    end
    check("stop_arm_no_fetch", fetch_seen, 0);

    // Async reset in the middle of ARM
    start = 1'b1; step(1); start = 1'b0;
    step(4);
    check("pre_areset_core_rst_n", core_rst_n, 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_state", state, 0);
    check("areset_core_rst_n", core_rst_n, 0);
    check("areset_fetch", fetch_en, 0);
    check("areset_boot_addr", boot_addr, 32'h0000_8000);
    check("areset_boot_count", boot_count, 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("no_reboot_after_areset", state, 0);

    // Watchdog
    boot_seq();
    check("wdt_boot_state", state, 3);
`ifdef PULPINO_BOOT_WDT_EN
    for (int k = 0; k < 4; k++) begin
      heartbeat = heartbeat + 32'd1;
      step(10);
      check("wdt_kicked_run", state, 3);
    end
    heartbeat = heartbeat + 32'd1;
    step(16);
    check("wdt_before_expire_state", state, 3);
    check("wdt_before_expire_flag", wdt_expired, 0);
    step(1);
    check("wdt_expire_state", state, 1);
    check("wdt_expire_flag", wdt_expired, 1);
    stop = 1'b1; step(1); stop = 1'b0;
    check("wdt_flag_sticky", wdt_expired, 1);
    start = 1'b1; step(1); start = 1'b0;
    check("wdt_flag_cleared", wdt_expired, 0);
    check("wdt_restart_state", state, 1);
    stop = 1'b1; step(1); stop = 1'b0;
`else
    left_run = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      left_run |= (state != 3'd3);
    end
    check("nowdt_stays_run", left_run, 0);
    check("nowdt_flag", wdt_expired, 0);
    stop = 1'b1; step(1); stop = 1'b0;
`endif
    check("wdt_section_idle", state, 0);

    // Boot counter saturation
    repeat (300) begin
      boot_seq();
      stop = 1'b1; step(1); stop = 1'b0;
    end
    check("boot_count_saturate", boot_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
